// File: rtl/seq_rotate_left.sv
// seq_rotate_left: iterative rotator that moves the operand one bit per clock.
// Rotating left by k undoes the combinational barrel rotator's rotation by k.
// The command side and the result side each use a valid/ready handshake.
// Optional feature macro ROTATE_DIR_EN adds a 'direction' input:
// 0 rotates left, 1 rotates right.
module seq_rotate_left #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] inputData,
  input  logic [SHW-1:0]   amount,
`ifdef ROTATE_DIR_EN
  input  logic             direction,
`endif
  output logic [WIDTH-1:0] outputData,
  output logic             outputValid,
  input  logic             outputReady
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [WIDTH-1:0] dataReg;
  logic [WIDTH-1:0] nextData;
  logic [SHW-1:0]   countReg;
  logic [SHW-1:0]   nextCount;
  logic [WIDTH-1:0] rotLeft;
`ifdef ROTATE_DIR_EN
  logic             dirReg;
  logic             nextDir;
  logic [WIDTH-1:0] rotRight;
`endif

  // One-position rotations of the held operand; no bit is lost or inserted.
  always_comb begin
    rotLeft = {dataReg[WIDTH-2:0], dataReg[WIDTH-1]};
`ifdef ROTATE_DIR_EN
    rotRight = {dataReg[0], dataReg[WIDTH-1:1]};
`endif
  end

  // State, operand, count and direction registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dataReg  <= '0;
      countReg <= '0;
`ifdef ROTATE_DIR_EN
      dirReg   <= 1'b0;
`endif
    end else begin
      state    <= nextState;
      dataReg  <= nextData;
      countReg <= nextCount;
`ifdef ROTATE_DIR_EN
      dirReg   <= nextDir;
`endif
    end
  end

  // Next-state logic: load on command, rotate once per BUSY cycle, hold until the result is taken.
  always_comb begin
    nextState = state;
    nextData  = dataReg;
    nextCount = countReg;
`ifdef ROTATE_DIR_EN
    nextDir   = dirReg;
`endif
    case (state)
      IDLE: begin
        if (startValid) begin
          nextData  = inputData;
          nextCount = amount;
`ifdef ROTATE_DIR_EN
          nextDir   = direction;
`endif
          // A zero rotation has nothing to iterate, so the result is ready straight away.
          if (amount == '0) begin
            nextState = DONE;
          end else begin
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
`ifdef ROTATE_DIR_EN
        nextData = dirReg ? rotRight : rotLeft;
`else
        nextData = rotLeft;
`endif
        nextCount = countReg - SHW'(1);
        // Leaving at a count of one means the counter never wraps below zero.
        if (countReg == SHW'(1)) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (outputReady) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Handshake flags come straight from the state; the result is the raw operand register.
  always_comb begin
    startReady  = (state == IDLE);
    outputValid = (state == DONE);
    outputData  = dataReg;
  end

endmodule

// File: tb/tb_seq_rotate_left.sv
// tb_seq_rotate_left: randomized and directed checks of seq_rotate_left against an arithmetic rotation model.
module tb_seq_rotate_left;

  localparam int WIDTH = 4;
  localparam int SHW   = 2;

  logic             clk;
  logic             rst;
  logic             startValid;
  logic             startReady;
  logic [WIDTH-1:0] inputData;
  logic [SHW-1:0]   amount;
  logic [WIDTH-1:0] outputData;
  logic             outputValid;
  logic             outputReady;
`ifdef ROTATE_DIR_EN
  logic             direction;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  seq_rotate_left #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk        (clk),
    .rst        (rst),
    .startValid (startValid),
    .startReady (startReady),
    .inputData  (inputData),
    .amount     (amount),
`ifdef ROTATE_DIR_EN
    .direction  (direction),
`endif
    .outputData (outputData),
    .outputValid(outputValid),
    .outputReady(outputReady)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference rotation: shift the value and wrap the overflow around, mod WIDTH.
  function automatic logic [WIDTH-1:0] modelRotate(input int d, input int a, input bit right);
    int s;
    int mask;
    mask = (1 << WIDTH) - 1;
    s = right ? (WIDTH - a) % WIDTH : a % WIDTH;
    return WIDTH'(((d << s) | (d >> (WIDTH - s))) & mask);
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int got, input int exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, verify busy cycles, result, optional backpressure hold and return to idle.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int a, input bit dir,
                               input logic [WIDTH-1:0] exp, input int hold);
    int cycles;
    @(negedge clk);
    checkOutput("cmdReady", int'(startReady), 1);
    startValid = 1'b1;
    inputData  = d;
    amount     = SHW'(a);
`ifdef ROTATE_DIR_EN
    direction  = dir;
`endif
    outputReady = (hold == 0);
    @(negedge clk);
    cycles = 0;
    while (!outputValid && cycles < WIDTH + 4) begin
      checkOutput("busyReady", int'(startReady), 0);
      startValid = 1'($urandom_range(0, 1));
      inputData  = WIDTH'($urandom);
      amount     = SHW'($urandom);
      @(negedge clk);
      cycles++;
    end
    startValid = 1'b0;
    checkOutput("busyCycles", cycles, a);
    checkOutput("result", int'(outputData), int'(exp));
    for (int i = 0; i < hold; i++) begin
      checkOutput("holdValid", int'(outputValid), 1);
      checkOutput("holdReady", int'(startReady), 0);
      checkOutput("holdData", int'(outputData), int'(exp));
      startValid = 1'($urandom_range(0, 1));
      inputData  = WIDTH'($urandom);
      amount     = SHW'($urandom);
      @(negedge clk);
    end
    startValid  = 1'b0;
    outputReady = 1'b1;
    @(negedge clk);
    checkOutput("idleValid", int'(outputValid), 0);
    checkOutput("idleReady", int'(startReady), 1);
  endtask

  initial begin
    int a;
    logic [WIDTH-1:0] d;
    bit dir;
    rst = 1'b1;
    startValid = 1'b0;
    inputData = '0;
    amount = '0;
    outputReady = 1'b1;
`ifdef ROTATE_DIR_EN
    direction = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rstValid", int'(outputValid), 0);
    checkOutput("rstData", int'(outputData), 0);
    checkOutput("rstReady", int'(startReady), 1);
    rst = 1'b0;

    $display("[TB] directed scenarios");
    applyStimulus(4'b1001, 1, 1'b0, 4'b0011, 0);
    applyStimulus(4'b0001, 3, 1'b0, 4'b1000, 0);
    applyStimulus(4'b1010, 0, 1'b0, 4'b1010, 0);
    applyStimulus(4'b0001, 3, 1'b0, 4'b1000, 5);

    // Reset during the second BUSY cycle aborts the command.
    @(negedge clk);
    startValid = 1'b1;
    inputData  = 4'b0110;
    amount     = 2'd3;
    @(negedge clk);
    startValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortValid", int'(outputValid), 0);
    checkOutput("abortData", int'(outputData), 0);
    checkOutput("abortReady", int'(startReady), 1);
    rst = 1'b0;
    applyStimulus(4'b0110, 2, 1'b0, 4'b1001, 0);

`ifdef ROTATE_DIR_EN
    applyStimulus(4'b0001, 1, 1'b1, 4'b1000, 0);
    applyStimulus(4'b0001, 1, 1'b0, 4'b0010, 0);
`endif

    $display("[TB] random commands");
    for (int n = 0; n < 40; n++) begin
      d = WIDTH'($urandom);
      a = $urandom_range(0, WIDTH - 1);
`ifdef ROTATE_DIR_EN
      dir = 1'($urandom_range(0, 1));
`else
      dir = 1'b0;
`endif
      applyStimulus(d, a, dir, modelRotate(int'(d), a, dir), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
